// File: rtl/rvfi_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_cmp_pkg
// Description : Shared types for the RVFI retirement comparator.
//               - rvfi_cmp_t   : the retirement fields compared per instruction
//               - c_MASK_*     : bit positions inside mismatch_mask_o
//               - cmp_state_e  : comparator run/halt state
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_cmp_pkg;

    // Data width of the packet fields. The comparator's XLEN parameter must
    // match this value.
    localparam int unsigned c_RVFI_XLEN   = 32;
    localparam int unsigned c_RVFI_MASK_W = c_RVFI_XLEN / 8;

    typedef struct packed {
        logic [63:0]                order;
        logic [31:0]                insn;
        logic                       trap;
        logic [c_RVFI_XLEN-1:0]     pc_rdata;
        logic [c_RVFI_XLEN-1:0]     pc_wdata;
        logic [4:0]                 rd1_addr;
        logic [c_RVFI_XLEN-1:0]     rd1_wdata;
        logic [c_RVFI_XLEN-1:0]     mem_addr;
        logic [c_RVFI_MASK_W-1:0]   mem_rmask;
        logic [c_RVFI_MASK_W-1:0]   mem_wmask;
        logic [c_RVFI_XLEN-1:0]     mem_rdata;
        logic [c_RVFI_XLEN-1:0]     mem_wdata;
    } rvfi_cmp_t;

    // Bit positions in the per-field mismatch mask
    localparam int unsigned c_MASK_ORDER     = 0;
    localparam int unsigned c_MASK_INSN      = 1;
    localparam int unsigned c_MASK_TRAP      = 2;
    localparam int unsigned c_MASK_PC_RDATA  = 3;
    localparam int unsigned c_MASK_PC_WDATA  = 4;
    localparam int unsigned c_MASK_RD1_ADDR  = 5;
    localparam int unsigned c_MASK_RD1_WDATA = 6;
    localparam int unsigned c_MASK_MEM       = 7;
    localparam int unsigned c_MASK_W         = 8;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } cmp_state_e;

endpackage
`default_nettype wire

// File: rtl/rvfi_retire_comparator_if.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_retire_comparator_if
// Description : Bundle of the two retirement streams and the comparison
//               result/status signals of rvfi_retire_comparator.
//               slave  : the comparator (consumes streams, drives results)
//               master : the stream source / result observer
// Ports       : dut_valid_i/dut_pkt_i, ref_valid_i/ref_pkt_i (streams);
//               cmp_valid_o, mismatch_o, mismatch_mask_o, cmp_order_o,
//               match_cnt_o, mismatch_cnt_o, overflow_o, halted_o (results)
// Revision    : 1.0 - initial release
// ============================================================================
interface rvfi_retire_comparator_if #(
    parameter int unsigned CNT_W = 32
);
    import rvfi_cmp_pkg::*;

    logic               dut_valid_i;
    rvfi_cmp_t          dut_pkt_i;
    logic               ref_valid_i;
    rvfi_cmp_t          ref_pkt_i;
    logic               cmp_valid_o;
    logic               mismatch_o;
    logic [7:0]         mismatch_mask_o;
    logic [63:0]        cmp_order_o;
    logic [CNT_W-1:0]   match_cnt_o;
    logic [CNT_W-1:0]   mismatch_cnt_o;
    logic               overflow_o;
    logic               halted_o;

    modport slave (
        input  dut_valid_i, dut_pkt_i, ref_valid_i, ref_pkt_i,
        output cmp_valid_o, mismatch_o, mismatch_mask_o, cmp_order_o,
               match_cnt_o, mismatch_cnt_o, overflow_o, halted_o
    );

    modport master (
        output dut_valid_i, dut_pkt_i, ref_valid_i, ref_pkt_i,
        input  cmp_valid_o, mismatch_o, mismatch_mask_o, cmp_order_o,
               match_cnt_o, mismatch_cnt_o, overflow_o, halted_o
    );

endinterface
`default_nettype wire

// File: rtl/rvfi_cmp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_cmp_fifo
// Description : Synchronous in-order FIFO of rvfi_cmp_t packets. Pointers
//               carry one extra wrap bit so full and empty are distinguished
//               without a separate occupancy counter. A push while full is
//               accepted only when a pop happens in the same cycle; otherwise
//               it is ignored (the caller flags the overflow).
// Ports       : clk_i, rst_ni (async, active-low)
//               i_push/i_data  : write strobe and packet
//               i_pop/o_data   : read strobe and head packet (show-ahead)
//               o_full/o_empty : status flags
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_cmp_fifo
    import rvfi_cmp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_push,
    input  rvfi_cmp_t   i_data,
    input  logic        i_pop,
    output rvfi_cmp_t   o_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [c_AW:0]  r_wptr;
    logic [c_AW:0]  r_rptr;
    rvfi_cmp_t      r_mem [DEPTH];
    logic           w_wr;
    logic           w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    // When full, the slot being written is the one being read this cycle;
    // the head is read combinationally before the edge, so this is safe.
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy is defined entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/rvfi_retire_comparator.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_retire_comparator
// Description : Buffers the DUT and ISS retirement streams in two in-order
//               FIFOs, pops them pairwise, compares field by field and
//               reports a registered result plus saturating match/mismatch
//               counters. Stops comparing (HALT) on FIFO overflow, and on
//               the first mismatch when HALT_ON_MISMATCH is set.
// Ports       : clk_i, rst_ni (async, active-low)
//               bus (slave)  : stream inputs and result outputs, see
//                              rvfi_retire_comparator_if
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_retire_comparator
    import rvfi_cmp_pkg::*;
#(
    parameter int unsigned XLEN             = c_RVFI_XLEN,
    parameter int unsigned DEPTH            = 4,
    parameter bit          HALT_ON_MISMATCH = 1'b1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    rvfi_retire_comparator_if.slave     bus
);

    rvfi_cmp_t              w_dut_head;
    rvfi_cmp_t              w_ref_head;
    logic                   w_dut_full;
    logic                   w_dut_empty;
    logic                   w_ref_full;
    logic                   w_ref_empty;

    cmp_state_e             r_state;
    cmp_state_e             w_state_nxt;
    logic                   w_pop;
    logic                   w_ovf_evt;
    logic [c_MASK_W-1:0]    w_mask;

    logic                   r_cmp_valid;
    logic                   r_mismatch;
    logic [c_MASK_W-1:0]    r_mask;
    logic [63:0]            r_order;
    logic [CNT_W-1:0]       r_match_cnt;
    logic [CNT_W-1:0]       r_mismatch_cnt;
    logic                   r_overflow;

    rvfi_cmp_fifo #(.DEPTH(DEPTH)) u_dut_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (bus.dut_valid_i),
        .i_data  (bus.dut_pkt_i),
        .i_pop   (w_pop),
        .o_data  (w_dut_head),
        .o_full  (w_dut_full),
        .o_empty (w_dut_empty)
    );

    rvfi_cmp_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (bus.ref_valid_i),
        .i_data  (bus.ref_pkt_i),
        .i_pop   (w_pop),
        .o_data  (w_ref_head),
        .o_full  (w_ref_full),
        .o_empty (w_ref_empty)
    );

    // Field comparison of the two FIFO heads. Register and memory data
    // checks are gated by the DUT's view of what is architecturally valid.
    always_comb begin
        w_mask = '0;
        w_mask[c_MASK_ORDER]     = (w_dut_head.order    != w_ref_head.order);
        w_mask[c_MASK_INSN]      = (w_dut_head.insn     != w_ref_head.insn);
        w_mask[c_MASK_TRAP]      = (w_dut_head.trap     != w_ref_head.trap);
        w_mask[c_MASK_PC_RDATA]  = (w_dut_head.pc_rdata != w_ref_head.pc_rdata);
        w_mask[c_MASK_PC_WDATA]  = (w_dut_head.pc_wdata != w_ref_head.pc_wdata);
        w_mask[c_MASK_RD1_ADDR]  = (w_dut_head.rd1_addr != w_ref_head.rd1_addr);
        w_mask[c_MASK_RD1_WDATA] = (w_dut_head.rd1_addr != 5'd0) &&
                                   (w_dut_head.rd1_wdata != w_ref_head.rd1_wdata);
        w_mask[c_MASK_MEM]       = (w_dut_head.mem_addr  != w_ref_head.mem_addr)  ||
                                   (w_dut_head.mem_rmask != w_ref_head.mem_rmask) ||
                                   (w_dut_head.mem_wmask != w_ref_head.mem_wmask);
        for (int b = 0; b < XLEN/8; b++) begin
            if (w_dut_head.mem_rmask[b] &&
                (w_dut_head.mem_rdata[8*b +: 8] != w_ref_head.mem_rdata[8*b +: 8]))
                w_mask[c_MASK_MEM] = 1'b1;
            if (w_dut_head.mem_wmask[b] &&
                (w_dut_head.mem_wdata[8*b +: 8] != w_ref_head.mem_wdata[8*b +: 8]))
                w_mask[c_MASK_MEM] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            RUN:     w_pop = !w_dut_empty && !w_ref_empty;
            default: w_pop = 1'b0;
        endcase
        // A pop frees a slot on both sides, so a same-cycle push is legal.
        w_ovf_evt = !w_pop && ((bus.dut_valid_i && w_dut_full) ||
                               (bus.ref_valid_i && w_ref_full));
        if (r_state == RUN) begin
            if (w_ovf_evt || (w_pop && HALT_ON_MISMATCH && (|w_mask)))
                w_state_nxt = HALT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cmp_valid    <= 1'b0;
            r_mismatch     <= 1'b0;
            r_mask         <= '0;
            r_order        <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_mismatch <= |w_mask;
                r_mask     <= w_mask;
                r_order    <= w_dut_head.order;
                if (|w_mask) begin
                    if (r_mismatch_cnt != '1) r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                end else begin
                    if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
                end
            end
            if (w_ovf_evt) r_overflow <= 1'b1;
        end
    end

    assign bus.cmp_valid_o     = r_cmp_valid;
    assign bus.mismatch_o      = r_mismatch;
    assign bus.mismatch_mask_o = r_mask;
    assign bus.cmp_order_o     = r_order;
    assign bus.match_cnt_o     = r_match_cnt;
    assign bus.mismatch_cnt_o  = r_mismatch_cnt;
    assign bus.overflow_o      = r_overflow;
    assign bus.halted_o        = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_rvfi_retire_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_retire_comparator
// Description : Self-checking bench. Two comparator instances share one
//               stimulus stream: instance a halts on mismatch with 32-bit
//               counters, instance b keeps running with 4-bit counters so
//               saturation is reachable. A queue-based reference model
//               predicts every output after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_comparator;
    import rvfi_cmp_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    rvfi_retire_comparator_if #(.CNT_W(32)) bus_a ();
    rvfi_retire_comparator_if #(.CNT_W(4))  bus_b ();

    rvfi_retire_comparator #(
        .XLEN(32), .DEPTH(DEPTH), .HALT_ON_MISMATCH(1'b1), .CNT_W(32)
    ) u_dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_a.slave)
    );

    rvfi_retire_comparator #(
        .XLEN(32), .DEPTH(DEPTH), .HALT_ON_MISMATCH(1'b0), .CNT_W(4)
    ) u_dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_b.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    rvfi_cmp_t   m_q [2][2][$];      // [instance][0=dut,1=iss]
    logic        e_valid [2];
    logic        e_mis   [2];
    logic        e_ovf   [2];
    logic        e_halt  [2];
    logic [7:0]  e_mask  [2];
    logic [63:0] e_order [2];
    logic [63:0] e_mc    [2];
    logic [63:0] e_mm    [2];

    function automatic logic [63:0] cnt_max(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [7:0] model_mask(input rvfi_cmp_t d, input rvfi_cmp_t r);
        logic [7:0] m;
        m    = 8'h00;
        m[0] = d.order    != r.order;
        m[1] = d.insn     != r.insn;
        m[2] = d.trap     != r.trap;
        m[3] = d.pc_rdata != r.pc_rdata;
        m[4] = d.pc_wdata != r.pc_wdata;
        m[5] = d.rd1_addr != r.rd1_addr;
        m[6] = (d.rd1_addr != 5'd0) && (d.rd1_wdata != r.rd1_wdata);
        m[7] = (d.mem_addr != r.mem_addr) || (d.mem_rmask != r.mem_rmask) ||
               (d.mem_wmask != r.mem_wmask) ||
               (((d.mem_rdata ^ r.mem_rdata) & lanes(d.mem_rmask)) != 32'h0) ||
               (((d.mem_wdata ^ r.mem_wdata) & lanes(d.mem_wmask)) != 32'h0);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i][0].delete();
            m_q[i][1].delete();
            e_valid[i] = 1'b0; e_mis[i] = 1'b0; e_ovf[i] = 1'b0; e_halt[i] = 1'b0;
            e_mask[i] = 8'h00; e_order[i] = 64'h0; e_mc[i] = 64'h0; e_mm[i] = 64'h0;
        end
    endtask

    task automatic model_step(input logic dv, input rvfi_cmp_t dp, input logic rv, input rvfi_cmp_t rp);
        for (int i = 0; i < 2; i++) begin
            logic       pop;
            logic       halt_nxt;
            logic [7:0] mk;
            rvfi_cmp_t  d;
            rvfi_cmp_t  r;
            halt_nxt   = e_halt[i];
            pop        = !e_halt[i] && (m_q[i][0].size() != 0) && (m_q[i][1].size() != 0);
            e_valid[i] = pop;
            if (pop) begin
                d = m_q[i][0].pop_front();
                r = m_q[i][1].pop_front();
                mk = model_mask(d, r);
                e_mask[i]  = mk;
                e_mis[i]   = (mk != 8'h00);
                e_order[i] = d.order;
                if (mk == 8'h00) begin
                    if (e_mc[i] < cnt_max(i)) e_mc[i] = e_mc[i] + 1;
                end else begin
                    if (e_mm[i] < cnt_max(i)) e_mm[i] = e_mm[i] + 1;
                    if (i == 0) halt_nxt = 1'b1;
                end
            end
            if (dv) begin
                if (m_q[i][0].size() < DEPTH) m_q[i][0].push_back(dp);
                else begin e_ovf[i] = 1'b1; halt_nxt = 1'b1; end
            end
            if (rv) begin
                if (m_q[i][1].size() < DEPTH) m_q[i][1].push_back(rp);
                else begin e_ovf[i] = 1'b1; halt_nxt = 1'b1; end
            end
            e_halt[i] = halt_nxt;
        end
    endtask

    // ---------------- output comparison ----------------
    task automatic compare_inst(input string n, input int i, input logic v, input logic mis,
                                input logic [7:0] mk, input logic [63:0] ord,
                                input logic [63:0] mc, input logic [63:0] mm,
                                input logic ov, input logic h, input logic all);
        check({n, ".cmp_valid"}, 64'(v), 64'(e_valid[i]));
        if (e_valid[i] || all) begin
            check({n, ".mismatch"}, 64'(mis), 64'(e_mis[i]));
            check({n, ".mask"},     64'(mk),  64'(e_mask[i]));
            check({n, ".order"},    ord,      e_order[i]);
        end
        check({n, ".match_cnt"},    mc, e_mc[i]);
        check({n, ".mismatch_cnt"}, mm, e_mm[i]);
        check({n, ".overflow"},     64'(ov), 64'(e_ovf[i]));
        check({n, ".halted"},       64'(h),  64'(e_halt[i]));
    endtask

    task automatic check_all(input logic all);
        compare_inst("a", 0, bus_a.cmp_valid_o, bus_a.mismatch_o, bus_a.mismatch_mask_o,
                     bus_a.cmp_order_o, 64'(bus_a.match_cnt_o), 64'(bus_a.mismatch_cnt_o),
                     bus_a.overflow_o, bus_a.halted_o, all);
        compare_inst("b", 1, bus_b.cmp_valid_o, bus_b.mismatch_o, bus_b.mismatch_mask_o,
                     bus_b.cmp_order_o, 64'(bus_b.match_cnt_o), 64'(bus_b.mismatch_cnt_o),
                     bus_b.overflow_o, bus_b.halted_o, all);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic dv, input rvfi_cmp_t dp, input logic rv, input rvfi_cmp_t rp);
        bus_a.dut_valid_i = dv; bus_a.dut_pkt_i = dp; bus_a.ref_valid_i = rv; bus_a.ref_pkt_i = rp;
        bus_b.dut_valid_i = dv; bus_b.dut_pkt_i = dp; bus_b.ref_valid_i = rv; bus_b.ref_pkt_i = rp;
    endtask

    // Inputs are applied 1 time unit after a rising edge, sampled at the
    // next edge, and outputs are checked 1 time unit after that edge.
    task automatic cyc_step(input logic dv, input rvfi_cmp_t dp, input logic rv, input rvfi_cmp_t rp);
        drive(dv, dp, rv, rp);
        @(posedge clk_i);
        model_step(dv, dp, rv, rp);
        #1;
        check_all(1'b0);
    endtask

    task automatic idle(input int n);
        rvfi_cmp_t z;
        z = '0;
        for (int k = 0; k < n; k++) cyc_step(1'b0, z, 1'b0, z);
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rvfi_cmp_t z;
        z = '0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all(1'b1);
        drive(1'b0, z, 1'b0, z);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic rvfi_cmp_t rand_pkt(input int ord);
        rvfi_cmp_t p;
        p.order     = 64'(ord);
        p.insn      = $urandom;
        p.trap      = ($urandom_range(0, 7) == 0);
        p.pc_rdata  = $urandom;
        p.pc_wdata  = $urandom;
        p.rd1_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p.rd1_wdata = $urandom;
        p.mem_addr  = $urandom;
        p.mem_rmask = 4'($urandom_range(0, 15));
        p.mem_wmask = 4'($urandom_range(0, 15));
        p.mem_rdata = $urandom;
        p.mem_wdata = $urandom;
        return p;
    endfunction

    function automatic rvfi_cmp_t corrupt(input rvfi_cmp_t p, input int k);
        logic [31:0] bit1;
        bit1 = 32'(1) << $urandom_range(0, 31);
        case (k)
            0:  p.order     = p.order ^ 64'h1;
            1:  p.insn      = p.insn ^ bit1;
            2:  p.trap      = ~p.trap;
            3:  p.pc_rdata  = p.pc_rdata ^ bit1;
            4:  p.pc_wdata  = p.pc_wdata ^ bit1;
            5:  p.rd1_addr  = p.rd1_addr ^ 5'h1;
            6:  p.rd1_wdata = p.rd1_wdata ^ bit1;
            7:  p.mem_addr  = p.mem_addr ^ bit1;
            8:  p.mem_rmask = p.mem_rmask ^ 4'h1;
            9:  p.mem_wmask = p.mem_wmask ^ 4'h2;
            10: p.mem_rdata = p.mem_rdata ^ bit1;
            default: p.mem_wdata = p.mem_wdata ^ bit1;
        endcase
        return p;
    endfunction

    rvfi_cmp_t pk [$];
    rvfi_cmp_t z_pkt;
    rvfi_cmp_t p;
    rvfi_cmp_t q;
    int        pulses;
    int        nd;
    int        nr;

    initial begin
        z_pkt = '0;
        drive(1'b0, z_pkt, 1'b0, z_pkt);
        model_reset();
        @(posedge clk_i);
        #1;
        check_all(1'b1);
        rst_ni = 1'b1;

        // Identical streams: 10 pairs in the same cycles
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            p = rand_pkt(k);
            cyc_step(1'b1, p, 1'b1, p);
            if (bus_a.cmp_valid_o) pulses++;
        end
        for (int k = 0; k < 2; k++) begin
            idle(1);
            if (bus_a.cmp_valid_o) pulses++;
        end
        check("ident.pulses", 64'(pulses), 64'd10);
        check("ident.match_cnt", 64'(bus_a.match_cnt_o), 64'd10);

        // Skewed arrival: ISS first, DUT three cycles later
        do_reset();
        for (int k = 0; k < 3; k++) cyc_step(1'b0, z_pkt, 1'b1, rand_pkt(100 + k) & '0 | pk_or(100 + k));
        idle(2);
        for (int k = 0; k < 3; k++) cyc_step(1'b1, pk_or(100 + k), 1'b0, z_pkt);
        idle(3);
        check("skew.match_cnt", 64'(bus_a.match_cnt_o), 64'd3);
        check("skew.overflow", 64'(bus_a.overflow_o), 64'd0);

        // pc_wdata mismatch on the 4th pair
        do_reset();
        for (int k = 0; k < 6; k++) begin
            p = rand_pkt(200 + k);
            q = p;
            if (k == 3) q.pc_wdata = q.pc_wdata ^ 32'h4;
            cyc_step(1'b1, p, 1'b1, q);
        end
        idle(3);
        check("mis.a_mask", 64'(bus_a.mismatch_mask_o), 64'h10);
        check("mis.a_halted", 64'(bus_a.halted_o), 64'd1);
        check("mis.b_mismatch_cnt", 64'(bus_b.mismatch_cnt_o), 64'd1);

        // Masking rules
        do_reset();
        p = rand_pkt(300); p.rd1_addr = 5'd0;
        q = p; q.rd1_wdata = ~q.rd1_wdata;
        cyc_step(1'b1, p, 1'b1, q);
        p = rand_pkt(301); p.mem_wmask = 4'b0011;
        q = p; q.mem_wdata = q.mem_wdata ^ 32'hFF00_0000;
        cyc_step(1'b1, p, 1'b1, q);
        p = rand_pkt(302); p.mem_wmask = 4'b0011;
        q = p; q.mem_wdata = q.mem_wdata ^ 32'h0000_0001;
        cyc_step(1'b1, p, 1'b1, q);
        idle(2);
        check("mask.a_match_cnt", 64'(bus_a.match_cnt_o), 64'd2);
        check("mask.a_mask", 64'(bus_a.mismatch_mask_o), 64'h80);

        // Overflow: five DUT pushes, no ISS traffic
        do_reset();
        for (int k = 0; k < 5; k++) cyc_step(1'b1, rand_pkt(400 + k), 1'b0, z_pkt);
        check("ovf.overflow", 64'(bus_a.overflow_o), 64'd1);
        check("ovf.halted", 64'(bus_a.halted_o), 64'd1);
        check("ovf.match_cnt", 64'(bus_a.match_cnt_o), 64'd0);

        // Reset with entries buffered, then a fresh pair
        do_reset();
        for (int k = 0; k < 2; k++) begin p = rand_pkt(500 + k); cyc_step(1'b1, p, 1'b1, p); end
        idle(2);
        for (int k = 0; k < 2; k++) cyc_step(1'b1, rand_pkt(510 + k), 1'b0, z_pkt);
        do_reset();
        p = rand_pkt(520);
        cyc_step(1'b1, p, 1'b1, p);
        idle(2);
        check("rst.match_cnt", 64'(bus_a.match_cnt_o), 64'd1);

        // Randomized traffic with occasional field corruption
        do_reset();
        nd = 0;
        nr = 0;
        for (int c = 0; c < 400; c++) begin
            logic dv;
            logic rv;
            rvfi_cmp_t dp;
            rvfi_cmp_t rp;
            dv = ($urandom_range(0, 1) == 1) && ((nd - nr) < DEPTH);
            rv = ($urandom_range(0, 1) == 1) && ((nr - nd) < DEPTH);
            dp = '0;
            rp = '0;
            if (dv) begin
                while (pk.size() <= nd) pk.push_back(rand_pkt(1000 + pk.size()));
                dp = pk[nd];
                nd++;
            end
            if (rv) begin
                while (pk.size() <= nr) pk.push_back(rand_pkt(1000 + pk.size()));
                rp = pk[nr];
                if ($urandom_range(0, 15) == 0) rp = corrupt(rp, $urandom_range(0, 11));
                nr++;
            end
            cyc_step(dv, dp, rv, rp);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Deterministic packet for the skew test, identical on both sides
    function automatic rvfi_cmp_t pk_or(input int ord);
        rvfi_cmp_t r;
        r           = '0;
        r.order     = 64'(ord);
        r.insn      = 32'h0000_0013 ^ 32'(ord << 7);
        r.pc_rdata  = 32'h8000_0000 + 32'(ord * 4);
        r.pc_wdata  = 32'h8000_0004 + 32'(ord * 4);
        r.rd1_addr  = 5'(ord % 32);
        r.rd1_wdata = 32'(ord * 32'h0101_0101);
        r.mem_addr  = 32'h1000_0000 + 32'(ord);
        r.mem_rmask = 4'(ord % 16);
        r.mem_wmask = 4'((ord + 5) % 16);
        r.mem_rdata = 32'hA5A5_0000 | 32'(ord);
        r.mem_wdata = 32'h5A5A_0000 | 32'(ord);
        return r;
    endfunction

endmodule
`default_nettype wire

// File: doc/rvfi_retire_comparator.md
# rvfi_retire_comparator

Consumer stage for the ISS reference pipeline. It takes the DUT retirement stream (RVFI) and the ISS retirement stream (reference-model RVFI output) and buffers each in a small in-order FIFO, because the two streams can arrive on different cycles. It pops one entry from each FIFO as a pair, compares the pair field by field and reports pass/fail with a per-field mask and saturating counters. It sits between the reference-model shell and the UVM scoreboard/logging.

## Interface
Parameters:
- XLEN, 32, register/PC/memory data width
- DEPTH, 4, entries per side FIFO (power of two, ≥2)
- HALT_ON_MISMATCH, 1, 1: stop comparing after first mismatch; 0: keep running
- CNT_W, 32, width of the match/mismatch counters

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dut_valid_i  in  1  DUT retirement strobe, one instruction per cycle
- dut_pkt_i  in  rvfi_cmp_t  DUT retirement fields
- ref_valid_i  in  1  ISS retirement strobe
- ref_pkt_i  in  rvfi_cmp_t  ISS retirement fields
- cmp_valid_o  out  1  comparison result valid (one-cycle pulse)
- mismatch_o  out  1  qualified by cmp_valid_o; 1 = pair differs
- mismatch_mask_o  out  8  per-field mismatch bits, qualified by cmp_valid_o
- cmp_order_o  out  64  DUT order field of the compared pair
- match_cnt_o  out  CNT_W  saturating count of matching pairs
- mismatch_cnt_o  out  CNT_W  saturating count of mismatching pairs
- overflow_o  out  1  sticky: a push arrived while that side's FIFO was full
- halted_o  out  1  state is HALT

## Operation
- **Push:** each side writes its FIFO on its valid strobe. If that FIFO is full and no pop happens in the same cycle, the packet is dropped, overflow_o is set (sticky) and the state goes to HALT.
- **Pop:** in RUN, when both FIFOs are non-empty, pop one entry from each in the same cycle and compare. A simultaneous push and pop on a full FIFO is legal; no overflow is raised.
- **Mask bits:** 0 order, 1 insn, 2 trap, 3 pc_rdata, 4 pc_wdata, 5 rd1_addr, 6 rd1_wdata, 7 memory.
- **rd1_wdata rule:** compared only if DUT rd1_addr != 0.
- **Memory bit:** set if mem_addr differs, rmask differs, wmask differs, or any byte of rdata/wdata differs where the DUT rmask/wmask bit is set. Unmasked bytes are ignored.
- **Result:** mismatch_o is the OR of the mask bits.
- **Counters:** match_cnt_o / mismatch_cnt_o increment on each result and saturate at all-ones (no wrap).
- **State machine:**
  - RUN → HALT on overflow, or on a mismatch result when HALT_ON_MISMATCH=1.
  - HALT: no further pops; pushes are still accepted while space remains; overflow can still be set.
  - HALT is left only by reset.

## Timing
- **Reset values:** all outputs 0, both FIFOs empty, state RUN. Reset is asynchronous, with synchronous deassert handled upstream.
- **Latency:** packet sampled at edge N is poppable at edge N+1. The result is registered at edge N+1, so cmp_valid_o is high in the cycle after edge N+1. Both valids in cycle 0 → result in cycle 2.
- **Throughput:** one comparison per cycle.
- **Counter/output update timing:** counters update at the same edge that registers the result and are visible together with cmp_valid_o. halted_o rises in the same cycle as the mismatching cmp_valid_o.
- **Reset mid-operation:** FIFO contents, counters and sticky flags are cleared immediately; no partial result is emitted.

## Structure
- Package rvfi_cmp_pkg holds:
  - the rvfi_cmp_t struct: order, insn, trap, pc_rdata, pc_wdata, rd1_addr, rd1_wdata, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata
  - mask-bit index localparams
  - the state enum (RUN, HALT)
- One sub-module, rvfi_cmp_fifo (parameterised DEPTH, synchronous FIFO with full/empty flags and an extra pointer wrap bit), instantiated twice.

## Test plan
- Identical streams: 10 equal packets on both sides in the same cycles → 10 cmp_valid_o pulses, each starting 2 cycles after its push; match_cnt_o=10; mismatch_cnt_o=0.
- Skewed arrival: ISS sends 3 packets in cycles 0–2, DUT sends 3 in cycles 5–7 → results in cycles 7–9, all matching, no overflow.
- Mismatches:
  - pc_wdata differs on the 4th pair, HALT_ON_MISMATCH=1 → mismatch_mask_o=8'h10; halted_o=1; no further cmp_valid_o.
  - Same case with HALT_ON_MISMATCH=0 → comparisons continue; mismatch_cnt_o=1.
- Masking: rd1_addr=0 with differing rd1_wdata → match. wmask=4'b0011 with wdata differing only in byte 3 → match; wdata differing in byte 0 → mask bit 7.
- Overflow: DEPTH=4, DUT pushes 5 packets with no ISS traffic → overflow_o=1 on the 5th push; halted_o=1; counters unchanged.
- Reset mid-stream: assert rst_ni low with 2 entries buffered → all outputs 0 asynchronously; after release, a fresh matching pair yields match_cnt_o=1.
